// File: rtl/mem_access_stage_if.sv
// Shared opcode/bus definitions and the EX / data-memory / writeback bundle of the MEM stage.
// The stage itself uses the master modport; its environment uses the slave modport.
package mem_access_pkg;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_ALUR = 7'b0110011;
  localparam logic [6:0] OP_ALUI = 7'b0010011;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] wb_value;
  } mem_wb_bus_t;
endpackage

interface mem_access_stage_if;
  import mem_access_pkg::*;

  logic        ex_valid;
  logic        ex_ready;
  logic [6:0]  ex_opcode;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;

  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_rdata;

  mem_wb_bus_t mem_wb_bus;
  logic        misaligned;

  modport master (
    input  ex_valid, ex_opcode, ex_rd, ex_alu_result, ex_store_data,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata,
    output ex_ready, dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata,
    output mem_wb_bus, misaligned
  );

  modport slave (
    output ex_valid, ex_opcode, ex_rd, ex_alu_result, ex_store_data,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata,
    input  ex_ready, dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata,
    input  mem_wb_bus, misaligned
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: ALU results pass through in one cycle, LW/SW run one data-memory
// transaction at a time while EX is stalled; idle cycles emit NOP bubbles to the regfile.
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter logic [6:0] NOP_OPCODE = 7'b0000000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  mem_access_stage_if.master stage_io
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  mem_wb_bus_t wb_q, wb_d;
  logic        mis_q, mis_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 5'd0;
      wb_q    <= {NOP_OPCODE, 5'd0, 32'd0};
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wb_d    = {NOP_OPCODE, 5'd0, 32'd0};
    mis_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (stage_io.ex_valid) begin
          case (stage_io.ex_opcode)
            OP_ALUR, OP_ALUI: begin
              wb_d = {stage_io.ex_opcode, stage_io.ex_rd, stage_io.ex_alu_result};
            end
            OP_LW, OP_SW: begin
              if (stage_io.ex_alu_result[1:0] == 2'b00) begin
                we_d    = (stage_io.ex_opcode == OP_SW);
                addr_d  = {stage_io.ex_alu_result[31:2], 2'b00};
                wdata_d = stage_io.ex_store_data;
                rd_d    = stage_io.ex_rd;
                state_d = REQ;
              end else begin
                mis_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      // Stores are posted: the request handshake completes them.
      REQ: begin
        if (stage_io.dmem_req_ready) begin
          state_d = we_q ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (stage_io.dmem_resp_valid) begin
          wb_d    = {OP_LW, rd_q, stage_io.dmem_resp_rdata};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stage_io.ex_ready       = (state_q == IDLE);
  assign stage_io.dmem_req_valid = (state_q == REQ);
  assign stage_io.dmem_req_we    = we_q;
  assign stage_io.dmem_req_addr  = addr_q;
  assign stage_io.dmem_req_wdata = wdata_q;
  assign stage_io.mem_wb_bus     = wb_q;
  assign stage_io.misaligned     = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Random + directed bench for mem_access_stage: a reference model predicts writeback words,
// memory requests and misaligned pulses; independent monitors compare them against the DUT.
module tb_mem_access_stage;
  import mem_access_pkg::*;

  localparam logic [6:0] NOP      = 7'b0000000;
  localparam logic [6:0] OP_OTHER = 7'b1100011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_stage_if bus ();

  mem_access_stage #(.NOP_OPCODE(NOP)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .stage_io (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    mem_wb_bus_t word;
    int          due;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  wb_exp_t     wb_q[$];
  req_t        req_q[$];
  int          mis_q[$];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] phys_mem[logic [31:0]];

  bit          resp_en      = 1'b1;
  bit          resp_pending = 1'b0;
  bit          force_resp   = 1'b0;
  int          resp_cnt     = 0;
  logic [31:0] resp_addr    = 32'd0;
  int          hold_low     = 0;

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected nothing (cycle %0d)", name, act, cyc);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ex_ready"}, 64'(bus.ex_ready), 64'd1);
    chk({tag, "_req_valid"}, 64'(bus.dmem_req_valid), 64'd0);
    chk({tag, "_req_we"}, 64'(bus.dmem_req_we), 64'd0);
    chk({tag, "_req_addr"}, 64'(bus.dmem_req_addr), 64'd0);
    chk({tag, "_req_wdata"}, 64'(bus.dmem_req_wdata), 64'd0);
    chk({tag, "_misaligned"}, 64'(bus.misaligned), 64'd0);
    chk({tag, "_mem_wb"}, 64'(bus.mem_wb_bus), 64'({NOP, 5'd0, 32'd0}));
  endtask

  // Present one instruction and hold it until accepted; record what the stage must do with it.
  task automatic issue(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] res,
                       input logic [31:0] sd, input bit track, output int waited);
    bit      r;
    wb_exp_t e;
    req_t    q;
    r = 1'b0;
    waited = 0;
    bus.ex_valid      = 1'b1;
    bus.ex_opcode     = op;
    bus.ex_rd         = rd;
    bus.ex_alu_result = res;
    bus.ex_store_data = sd;
    do begin
      @(negedge clk);
      r = bus.ex_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!r && waited < 200);
    if (!r) begin
      fail_now("accept_timeout", 64'(waited));
      bus.ex_valid = 1'b0;
      return;
    end
    $display("issue op=%b rd=%0d res=%h sd=%h cycle=%0d", op, rd, res, sd, cyc);
    if (op == OP_ALUR || op == OP_ALUI) begin
      e.word = {op, rd, res};
      e.due  = cyc;
      wb_q.push_back(e);
    end else if (op == OP_LW || op == OP_SW) begin
      if (res[1:0] != 2'b00) begin
        mis_q.push_back(cyc);
      end else begin
        q.we    = (op == OP_SW);
        q.addr  = res;
        q.wdata = sd;
        req_q.push_back(q);
        if (op == OP_SW) begin
          model_mem[res] = sd;
        end else if (track) begin
          e.word = {OP_LW, rd, (model_mem.exists(res) ? model_mem[res] : mem_init(res))};
          e.due  = -1;
          wb_q.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    bus.ex_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    bus.ex_valid = 1'b0;
    while ((wb_q.size() != 0 || req_q.size() != 0 || mis_q.size() != 0 || resp_pending ||
            bus.dmem_req_valid) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 300) fail_now("drain_timeout", 64'(wb_q.size()));
    idle(2);
  endtask

  // Data memory: random ready, random response latency, occasional stray responses.
  initial begin : responder
    logic hs;
    req_t r, e;
    bus.dmem_req_ready  = 1'b0;
    bus.dmem_resp_valid = 1'b0;
    bus.dmem_resp_rdata = 32'd0;
    forever begin
      @(negedge clk);
      hs      = rst_n && bus.dmem_req_valid && bus.dmem_req_ready;
      r.we    = bus.dmem_req_we;
      r.addr  = bus.dmem_req_addr;
      r.wdata = bus.dmem_req_wdata;
      @(posedge clk);
      #1;
      bus.dmem_resp_valid = 1'b0;
      if (hs) begin
        if (req_q.size() == 0) begin
          fail_now("unexpected_req", 64'(r.addr));
        end else begin
          e = req_q.pop_front();
          chk("req_we", 64'(r.we), 64'(e.we));
          chk("req_addr", 64'(r.addr), 64'(e.addr));
          if (e.we) chk("req_wdata", 64'(r.wdata), 64'(e.wdata));
        end
        $display("mem %s addr=%h wdata=%h cycle=%0d", r.we ? "store" : "load", r.addr, r.wdata, cyc);
        if (r.we) begin
          phys_mem[r.addr] = r.wdata;
        end else begin
          resp_pending = 1'b1;
          resp_addr    = r.addr;
          resp_cnt     = int'($urandom_range(0, 4));
        end
      end
      if (force_resp) begin
        bus.dmem_resp_valid = 1'b1;
        bus.dmem_resp_rdata = 32'hBAD0BAD0;
        force_resp = 1'b0;
      end else if (resp_pending && resp_en) begin
        if (resp_cnt == 0) begin
          bus.dmem_resp_valid = 1'b1;
          bus.dmem_resp_rdata = phys_mem.exists(resp_addr) ? phys_mem[resp_addr] : mem_init(resp_addr);
          resp_pending = 1'b0;
        end else begin
          resp_cnt--;
        end
      end else if (!resp_pending && $urandom_range(0, 9) == 0) begin
        bus.dmem_resp_valid = 1'b1;
        bus.dmem_resp_rdata = $urandom;
      end
      if (hold_low > 0) begin
        bus.dmem_req_ready = 1'b0;
        hold_low--;
      end else begin
        bus.dmem_req_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Output monitor: pops the scoreboards whenever the DUT presents a word or a pulse.
  initial begin : monitor
    bit          prev_stall;
    logic [64:0] prev_req;
    wb_exp_t     e;
    int          m;
    prev_stall = 1'b0;
    prev_req   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (bus.mem_wb_bus.opcode != NOP) begin
          if (wb_q.size() == 0) begin
            fail_now("unexpected_wb", 64'(bus.mem_wb_bus));
          end else begin
            e = wb_q.pop_front();
            chk("wb_word", 64'(bus.mem_wb_bus), 64'(e.word));
            if (e.due >= 0) chk("wb_latency", 64'(cyc), 64'(e.due));
          end
          $display("wb op=%b rd=%0d val=%h cycle=%0d", bus.mem_wb_bus.opcode,
                   bus.mem_wb_bus.rd, bus.mem_wb_bus.wb_value, cyc);
        end
        if (bus.misaligned) begin
          if (mis_q.size() == 0) begin
            fail_now("unexpected_misaligned", 64'(cyc));
          end else begin
            m = mis_q.pop_front();
            chk("misaligned_cycle", 64'(cyc), 64'(m));
          end
        end
        if (bus.dmem_req_valid || resp_pending) chk("ex_ready_busy", 64'(bus.ex_ready), 64'd0);
        if (bus.dmem_req_valid) chk("req_addr_align", 64'(bus.dmem_req_addr[1:0]), 64'd0);
        if (prev_stall) begin
          chk("req_hold_valid", 64'(bus.dmem_req_valid), 64'd1);
          chk("req_hold_fields", 64'({bus.dmem_req_we, bus.dmem_req_addr, bus.dmem_req_wdata}),
              64'(prev_req));
        end
        prev_stall = bus.dmem_req_valid && !bus.dmem_req_ready;
        prev_req   = {bus.dmem_req_we, bus.dmem_req_addr, bus.dmem_req_wdata};
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int          w, k, sel;
    logic [31:0] a;
    logic [6:0]  op;
    bus.ex_valid      = 1'b0;
    bus.ex_opcode     = NOP;
    bus.ex_rd         = 5'd0;
    bus.ex_alu_result = 32'd0;
    bus.ex_store_data = 32'd0;
    model_mem[32'h40] = 32'hDEADBEEF;
    phys_mem[32'h40]  = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    idle(1);

    issue(OP_ALUR, 5'd5, 32'h1234, 32'd0, 1'b1, w);
    idle(2);
    issue(OP_LW, 5'd7, 32'h40, 32'd0, 1'b1, w);
    drain();
    chk("ex_ready_after_lw", 64'(bus.ex_ready), 64'd1);
    hold_low = 6;
    issue(OP_SW, 5'd0, 32'h80, 32'hA5A5A5A5, 1'b1, w);
    drain();
    issue(OP_LW, 5'd9, 32'h42, 32'd0, 1'b1, w);
    issue(OP_ALUI, 5'd1, 32'h1111, 32'd0, 1'b1, w);
    chk("accept_after_misaligned", 64'(w), 64'd1);
    for (int i = 0; i < 3; i++) begin
      issue(OP_ALUI, 5'(10 + i), 32'hA000 + 32'(i), 32'd0, 1'b1, w);
      chk("back_to_back_accept", 64'(w), 64'd1);
    end
    drain();

    // Reset while a load waits for its response: the load must vanish.
    resp_en = 1'b0;
    issue(OP_LW, 5'd3, 32'h100, 32'd0, 1'b0, w);
    bus.ex_valid = 1'b0;
    k = 0;
    while (!resp_pending && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("lw_reached_wait", 64'(resp_pending), 64'd1);
    idle(2);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    resp_pending = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    resp_en = 1'b1;
    @(negedge clk);
    force_resp = 1'b1;
    idle(4);
    chk("ex_ready_after_midreset", 64'(bus.ex_ready), 64'd1);

    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 9));
      op  = (sel < 3) ? OP_ALUR : (sel < 5) ? OP_ALUI : (sel < 7) ? OP_LW : (sel < 9) ? OP_SW : OP_OTHER;
      if (op == OP_LW || op == OP_SW) begin
        a = 32'($urandom_range(0, 63)) << 2;
        a[31] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      end else begin
        a = $urandom;
      end
      issue(op, 5'($urandom_range(0, 31)), a, $urandom, 1'b1, w);
      if ($urandom_range(0, 9) < 3) idle(int'($urandom_range(0, 2)));
    end
    drain();

    chk("wb_queue_empty", 64'(wb_q.size()), 64'd0);
    chk("req_queue_empty", 64'(req_q.size()), 64'd0);
    chk("mis_queue_empty", 64'(mis_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
